// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and stall/flush controller for the 5-stage core.
// Detects load-use hazards, squashes younger stages on taken branches and
// jumps, freezes the pipe while memory is busy, and drains older
// instructions before raising a sticky halt. A saturating counter records
// the number of cycles the PC was held, for performance debug.
//
// state       | meaning
// ------------+----------------------------------------------------------
// RUN         | normal issue; hazards, branches, jumps and HLT decoded
// LU_STALL    | extra load-use bubbles still being inserted
// DRAIN       | HLT seen; waiting for older instructions to retire
// HALTED      | pipe frozen, hlt asserted; only reset leaves this state
module pipe_hazard_ctrl #(
  parameter int REG_AW         = 4,
  parameter int BR_FLUSH_DEPTH = 2,
  parameter int LU_BUBBLES     = 1,
  parameter int HLT_DRAIN      = 3,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_hlt,
  input  logic              jmp_taken,
  input  logic              ex_re_mem,
  input  logic              ex_we_rf,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              stall_id_ex,
  output logic              stall_ex_mem,
  output logic              stall_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              hlt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [2:0]       LU_INIT    = 3'(LU_BUBBLES - 1);
  localparam logic [2:0]       DRAIN_INIT = 3'(HLT_DRAIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic             BR_FL_EX   = (BR_FLUSH_DEPTH >= 2);
  localparam logic             LU_MULTI   = (LU_BUBBLES > 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic             r_hlt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu_haz;
  logic w_stall_pc;
  logic w_stall_if_id;
  logic w_stall_id_ex;
  logic w_stall_ex_mem;
  logic w_stall_mem_wb;
  logic w_flush_if_id;
  logic w_flush_id_ex;

  // R0 reads as zero, so a load targeting it can never feed a dependent op.
  assign w_lu_haz = id_valid & ex_re_mem & ex_we_rf & (ex_dst != '0) &
                    ((id_uses_rs & (id_rs == ex_dst)) |
                     (id_uses_rt & (id_rt == ex_dst)));

  // Next-state and same-cycle stall/flush decode, memory wait has top priority.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_stall_mem_wb = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    if (mem_busy) begin
      w_stall_pc     = 1'b1;
      w_stall_if_id  = 1'b1;
      w_stall_id_ex  = 1'b1;
      w_stall_ex_mem = 1'b1;
      w_stall_mem_wb = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (br_taken) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = BR_FL_EX;
            w_cnt_nxt     = 3'd0;
          end else if (w_lu_haz) begin
            w_stall_pc    = 1'b1;
            w_stall_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            if (LU_MULTI) begin
              w_state_nxt = ST_LU_STALL;
              w_cnt_nxt   = LU_INIT;
            end
          end else if (jmp_taken) begin
            w_flush_if_id = 1'b1;
          end else if (id_valid && id_is_hlt) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = DRAIN_INIT;
          end
        end
        ST_LU_STALL: begin
          if (br_taken) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = BR_FL_EX;
            w_state_nxt   = ST_RUN;
            w_cnt_nxt     = 3'd0;
          end else begin
            w_stall_pc    = 1'b1;
            w_stall_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            // A zero count here is not reachable; treat it as the last bubble.
            if (r_cnt <= 3'd1) begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = 3'd0;
            end else begin
              w_cnt_nxt = r_cnt - 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          w_stall_pc    = 1'b1;
          w_stall_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
          if (r_cnt == 3'd0) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        ST_HALTED: begin
          w_stall_pc     = 1'b1;
          w_stall_if_id  = 1'b1;
          w_stall_id_ex  = 1'b1;
          w_stall_ex_mem = 1'b1;
          w_stall_mem_wb = 1'b1;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // State, bubble/drain counter and sticky halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
      r_hlt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_state_nxt == ST_HALTED) begin
        r_hlt <= 1'b1;
      end
    end
  end

  // Saturating count of PC-hold cycles; frozen once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_pc && (r_state != ST_HALTED) && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held, regardless of inputs.
  assign stall_pc     = rst_n & w_stall_pc;
  assign stall_if_id  = rst_n & w_stall_if_id;
  assign stall_id_ex  = rst_n & w_stall_id_ex;
  assign stall_ex_mem = rst_n & w_stall_ex_mem;
  assign stall_mem_wb = rst_n & w_stall_mem_wb;
  assign flush_if_id  = rst_n & w_flush_if_id;
  assign flush_id_ex  = rst_n & w_flush_id_ex;
  assign hlt          = r_hlt;
  assign stall_cnt    = r_stall_cnt;
  assign state        = r_state;

endmodule
